// File: rtl/m_mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding, port IDs,
// downstream memory widths and a small pending-request helper.
package m_mem_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } arb_state_e;

  function automatic logic is_pending(input logic ren, input logic [WEN_W-1:0] wen);
    return ren | (|wen);
  endfunction

endpackage

// File: rtl/m_mem_arbiter_if.sv
// Bundle of the two requester ports and the downstream cached-memory port.
interface m_mem_arbiter_if
  import m_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              i_p0_ren;
  logic [WEN_W-1:0]  i_p0_wen;
  logic [ADDR_W-1:0] i_p0_addr;
  logic [DATA_W-1:0] i_p0_data;
  logic [DATA_W-1:0] o_p0_data;
  logic              o_p0_stall;

  logic              i_p1_ren;
  logic [WEN_W-1:0]  i_p1_wen;
  logic [ADDR_W-1:0] i_p1_addr;
  logic [DATA_W-1:0] i_p1_data;
  logic [DATA_W-1:0] o_p1_data;
  logic              o_p1_stall;

  logic              o_m_ren;
  logic [WEN_W-1:0]  o_m_wen;
  logic [ADDR_W-1:0] o_m_addr;
  logic [DATA_W-1:0] o_m_data;
  logic [DATA_W-1:0] i_m_data;
  logic              i_m_stall;

  modport slave (
    input  i_p0_ren, i_p0_wen, i_p0_addr, i_p0_data,
    output o_p0_data, o_p0_stall,
    input  i_p1_ren, i_p1_wen, i_p1_addr, i_p1_data,
    output o_p1_data, o_p1_stall,
    output o_m_ren, o_m_wen, o_m_addr, o_m_data,
    input  i_m_data, i_m_stall
  );

  modport master (
    output i_p0_ren, i_p0_wen, i_p0_addr, i_p0_data,
    input  o_p0_data, o_p0_stall,
    output i_p1_ren, i_p1_wen, i_p1_addr, i_p1_data,
    input  o_p1_data, o_p1_stall,
    input  o_m_ren, o_m_wen, o_m_addr, o_m_data,
    output i_m_data, i_m_stall
  );

endinterface

// File: rtl/m_mem_arbiter.sv
// Two-port (data/fetch) arbiter in front of a single stalling cached memory.
// One request outstanding at a time; ties alternate; back-to-back issue on completion.
module m_mem_arbiter
  import m_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int P0_FIRST = 1
) (
  input logic           i_clk,
  input logic           rst,
  m_mem_arbiter_if.slave bus
);

  localparam logic LAST_RST = (P0_FIRST != 0) ? PORT_I : PORT_D;

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic              last_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [WEN_W-1:0]  wen_r;
  logic [DATA_W-1:0] hold0_r;
  logic [DATA_W-1:0] hold1_r;

  logic              pend0_s;
  logic              pend1_s;
  logic              issue_s;
  logic              grant_s;
  logic              done0_s;
  logic              done1_s;
  logic              rd_done_s;
  logic              g_ren_s;
  logic [WEN_W-1:0]  g_wen_s;
  logic [ADDR_W-1:0] g_addr_s;
  logic [DATA_W-1:0] g_data_s;

  // Arbitration: decide issue/grant/completion and the next state.
  always_comb begin
    pend0_s     = is_pending(bus.i_p0_ren, bus.i_p0_wen);
    pend1_s     = is_pending(bus.i_p1_ren, bus.i_p1_wen);
    issue_s     = 1'b0;
    grant_s     = PORT_D;
    done0_s     = 1'b0;
    done1_s     = 1'b0;
    state_nxt_s = state_r;
    if (rst) begin
      state_nxt_s = IDLE;
    end else if (!bus.i_m_stall) begin
      case (state_r)
        IDLE: begin
          if (pend0_s && pend1_s) begin
            issue_s = 1'b1;
            grant_s = ~last_r;
          end else if (pend0_s) begin
            issue_s = 1'b1;
            grant_s = PORT_D;
          end else if (pend1_s) begin
            issue_s = 1'b1;
            grant_s = PORT_I;
          end else begin
            issue_s = 1'b0;
          end
        end
        // The completing port's held request is finished; only the other may issue.
        BUSY0: begin
          done0_s = 1'b1;
          if (pend1_s) begin
            issue_s = 1'b1;
            grant_s = PORT_I;
          end else begin
            issue_s = 1'b0;
          end
        end
        BUSY1: begin
          done1_s = 1'b1;
          if (pend0_s) begin
            issue_s = 1'b1;
            grant_s = PORT_D;
          end else begin
            issue_s = 1'b0;
          end
        end
        default: begin
          issue_s = 1'b0;
        end
      endcase
      if (issue_s) begin
        state_nxt_s = (grant_s == PORT_D) ? BUSY0 : BUSY1;
      end else if (done0_s || done1_s) begin
        state_nxt_s = IDLE;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Granted-port request mux and downstream/port output drive.
  always_comb begin
    if (grant_s == PORT_I) begin
      g_ren_s  = bus.i_p1_ren;
      g_wen_s  = bus.i_p1_wen;
      g_addr_s = bus.i_p1_addr;
      g_data_s = bus.i_p1_data;
    end else begin
      g_ren_s  = bus.i_p0_ren;
      g_wen_s  = bus.i_p0_wen;
      g_addr_s = bus.i_p0_addr;
      g_data_s = bus.i_p0_data;
    end
    rd_done_s = (wen_r == 4'b0000);
    if (issue_s) begin
      bus.o_m_ren  = g_ren_s & (g_wen_s == 4'b0000);
      bus.o_m_wen  = g_wen_s;
      bus.o_m_addr = g_addr_s;
      bus.o_m_data = g_data_s;
    end else begin
      bus.o_m_ren  = 1'b0;
      bus.o_m_wen  = 4'b0000;
      bus.o_m_addr = addr_r;
      bus.o_m_data = data_r;
    end
    bus.o_p0_stall = pend0_s & ~done0_s;
    bus.o_p1_stall = pend1_s & ~done1_s;
    // Hold registers may still be stale in the first reset cycle, so force zero.
    if (rst) begin
      bus.o_p0_data = 32'h0000_0000;
      bus.o_p1_data = 32'h0000_0000;
    end else begin
      bus.o_p0_data = (done0_s && rd_done_s) ? bus.i_m_data : hold0_r;
      bus.o_p1_data = (done1_s && rd_done_s) ? bus.i_m_data : hold1_r;
    end
  end

  // State, tie-break memory, issued-request and read-result registers.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= LAST_RST;
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= 32'h0000_0000;
      wen_r   <= 4'b0000;
      hold0_r <= 32'h0000_0000;
      hold1_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (issue_s) begin
        last_r <= grant_s;
        addr_r <= g_addr_s;
        data_r <= g_data_s;
        wen_r  <= g_wen_s;
      end
      if (done0_s && rd_done_s) begin
        hold0_r <= bus.i_m_data;
      end
      if (done1_s && rd_done_s) begin
        hold1_r <= bus.i_m_data;
      end
    end
  end

endmodule

// File: doc/m_mem_arbiter.md
M_MEM_ARBITER -- requirements
Module: m_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter P0_FIRST, default 1, meaning port 0 wins the first tie after reset (0: port 1 wins).
REQ-003 i_clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_pN_ren  in  1  port N (N=0 data, N=1 fetch) read request, held until stall low.
REQ-006 i_pN_wen  in  4  port N byte write enables; nonzero means write; wins over i_pN_ren.
REQ-007 i_pN_addr  in  ADDR_W  port N byte address; i_pN_data  in  32  port N write data.
REQ-008 o_pN_data  out  32  port N read data; o_pN_stall  out  1  port N request not yet complete.
REQ-009 o_m_ren  out  1, o_m_wen  out  4, o_m_addr  out  ADDR_W, o_m_data  out  32: downstream cached-memory request.
REQ-010 i_m_data  in  32  downstream read data; i_m_stall  in  1  downstream busy, calibration included.

Function
REQ-011 SHALL implement states IDLE, BUSY0, BUSY1 (BUSYn = one request of port n outstanding downstream).
REQ-012 Pending(N) SHALL be i_pN_ren or i_pN_wen != 0.
REQ-013 Issue SHALL occur only in a cycle with i_m_stall low; downstream accepts the request at that clock edge.
REQ-014 In IDLE with i_m_stall low: one pending port issues it; both pending, the port not equal to r_last issues; next state BUSYn.
REQ-015 On issue the arbiter SHALL drive o_m_ren/o_m_wen from the granted port for that cycle only, set r_last to n, and register addr/data/wen.
REQ-016 Outside issue cycles o_m_ren=0, o_m_wen=0; o_m_addr/o_m_data SHALL hold the last issued values.
REQ-017 In BUSYn, i_m_stall high: remain in BUSYn, issue nothing.
REQ-018 In BUSYn, i_m_stall low: completion cycle; o_pn_stall=0; for reads o_pn_data = i_m_data combinationally and captured into the port-n hold register.
REQ-019 In a completion cycle, if the other port m is pending, it SHALL issue in the same cycle (back-to-back) and go to BUSYm; otherwise go to IDLE.
REQ-020 Port n SHALL NOT be reissued in its own completion cycle; its held request counts as completed.
REQ-021 o_pN_stall SHALL be 1 whenever Pending(N) and port N is not in its completion cycle; 0 when not pending.
REQ-022 o_pN_data outside completion cycles SHALL equal the port-N hold register (last read result).
REQ-023 Minimum read latency SHALL be 1 cycle (issue at T, completion at T+1 on cache hit); no fixed upper bound.
REQ-024 Under continuous contention grants SHALL alternate 0,1,0,1; neither port waits more than one foreign transaction.
REQ-025 Write completion SHALL also require i_m_stall low after issue; o_pN_data unchanged by writes.
REQ-026 Request inputs changing while stalled are unsupported; arbiter SHALL use values registered at issue.

Reset
REQ-027 On rst: state IDLE, r_last = P0_FIRST ? 1 : 0, hold registers 0, address/data registers 0.
REQ-028 During rst: o_m_ren=0, o_m_wen=0, o_pN_data=0, o_pN_stall=Pending(N).
REQ-029 Reset mid-BUSYn SHALL discard the outstanding request; the next issue SHALL wait for i_m_stall low.

Structure
REQ-030 State encodings and port IDs (PORT_D=0, PORT_I=1) SHALL live in a shared package/header with the memory defines.
REQ-031 Single flat module; no sub-module required.

Verification
REQ-032 Calibration: i_m_stall=1 for 50 cycles, p0 read 0x100 pending -> no o_m_ren, o_p0_stall=1; first issue the cycle i_m_stall falls.
REQ-033 Hit: p1 read 0x40, downstream stall low, i_m_data=0xDEADBEEF at T+1 -> o_p1_stall low at T+1, o_p1_data=0xDEADBEEF, held afterwards.
REQ-034 Contention: both ports read every cycle after reset (P0_FIRST=1) -> issue order p0,p1,p0,p1, back-to-back, one o_m_ren per issue.
REQ-035 Miss: p0 wen=4'b0011 addr 0x200 data 0x1234, i_m_stall high 20 cycles -> single o_m_wen pulse, o_p0_stall high 20 cycles, o_p1 unaffected when idle.
REQ-036 Reset in BUSY1 -> state IDLE, outputs per REQ-028, no duplicate issue until i_m_stall low.
